// File: rtl/nasti_trans_pkg.sv
// Shared NASTI transaction types, burst/response encodings, engine FSM
// states and the per-beat address stepping function.
package nasti_trans_pkg;

    localparam int C_NASTI_ID_WIDTH   = 9;
    localparam int C_NASTI_ADDR_WIDTH = 16;
    localparam int C_NASTI_DATA_WIDTH = 64;
    localparam int C_NASTI_USER_WIDTH = 1;
    localparam int C_NASTI_STRB_WIDTH = C_NASTI_DATA_WIDTH / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AR and AW carry the same header fields.
    typedef struct packed {
        logic [C_NASTI_ID_WIDTH-1:0]   id;
        logic [C_NASTI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                    len;
        logic [2:0]                    size;
        logic [1:0]                    burst;
        logic [C_NASTI_USER_WIDTH-1:0] user;
    } ax_trans;

    typedef ax_trans ar_trans;
    typedef ax_trans aw_trans;

    typedef struct packed {
        logic [C_NASTI_DATA_WIDTH-1:0] data;
        logic [C_NASTI_STRB_WIDTH-1:0] strb;
        logic                          last;
        logic [C_NASTI_USER_WIDTH-1:0] user;
    } w_trans;

    typedef struct packed {
        logic [C_NASTI_ID_WIDTH-1:0]   id;
        logic [C_NASTI_DATA_WIDTH-1:0] data;
        logic                          last;
        logic [1:0]                    resp;
        logic [C_NASTI_USER_WIDTH-1:0] user;
    } r_trans;

    typedef struct packed {
        logic [C_NASTI_ID_WIDTH-1:0]   id;
        logic [1:0]                    resp;
        logic [C_NASTI_USER_WIDTH-1:0] user;
    } b_trans;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_WR_RESP  = 2'd3
    } eng_state_e;

    // Address of the beat following 'addr'. Reserved burst 2'b11 steps like INCR.
    function automatic logic [C_NASTI_ADDR_WIDTH-1:0] next_addr(
        input logic [C_NASTI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                    size,
        input logic [1:0]                    burst,
        input logic [7:0]                    len
    );
        logic [C_NASTI_ADDR_WIDTH-1:0] sz;
        logic [C_NASTI_ADDR_WIDTH-1:0] wb;
        sz = C_NASTI_ADDR_WIDTH'(1) << size;
        wb = (C_NASTI_ADDR_WIDTH'(len) + C_NASTI_ADDR_WIDTH'(1)) * sz;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~(wb - 1'b1)) | ((addr + sz) & (wb - 1'b1));
            default:     next_addr = (addr & ~(sz - 1'b1)) + sz;
        endcase
    endfunction

endpackage

// File: rtl/nasti_tag_fifo.sv
// Read tag FIFO: remembers {id, user, last} for every issued read beat so
// the in-order memory return can be labelled. DEPTH must be a power of 2.
module nasti_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rptr[PW-1:0]];

    // Storage and pointers; a simultaneous push and pop keeps the count.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[PW-1:0]] <= i_din;
                r_wptr <= r_wptr + {{PW{1'b0}}, 1'b1};
            end
            if (w_do_pop) r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/nasti_burst_engine.sv
// Core-clock NASTI burst engine: pops AR/AW/W frontend FIFOs, expands each
// burst into per-beat memory commands and returns R beats / B responses.
// Optional feature macro NASTI_WLAST_CHECK_EN: when defined, a W beat whose
// last flag disagrees with the beat count marks the burst SLVERR.
// Handshakes: a command transfers on the clock edge where cmd_valid and
// cmd_ready are both high; once raised, cmd_valid holds its payload stable
// until that edge. rd_valid/rd_ready follow the same rule. FIFO pops/pushes
// (rinc_*/winc_*) take effect on the edge where they are high.
module nasti_burst_engine
    import nasti_trans_pkg::*;
#(
    parameter int C_RD_TAGS = 8
) (
    input  logic                          core_clk,
    input  logic                          core_arstn,
    input  ar_trans                       rdata_ar,
    input  logic                          rempty_ar,
    output logic                          rinc_ar,
    input  aw_trans                       rdata_aw,
    input  logic                          rempty_aw,
    output logic                          rinc_aw,
    input  w_trans                        rdata_w,
    input  logic                          rempty_w,
    output logic                          rinc_w,
    output r_trans                        wdata_r,
    input  logic                          wfull_r,
    output logic                          winc_r,
    output b_trans                        wdata_b,
    input  logic                          wfull_b,
    output logic                          winc_b,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_we,
    output logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr,
    output logic [C_NASTI_DATA_WIDTH-1:0] cmd_wdata,
    output logic [C_NASTI_STRB_WIDTH-1:0] cmd_wstrb,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [C_NASTI_DATA_WIDTH-1:0] rd_data,
    output logic [1:0]                    dbg_state
);
    localparam int TAG_W = C_NASTI_ID_WIDTH + C_NASTI_USER_WIDTH + 1;

    eng_state_e       r_state;
    eng_state_e       w_next;
    ax_trans          r_hdr;
    logic [7:0]       r_beat;
    logic             r_last_rd;
    logic             r_rinc_ar;
    logic             r_rinc_aw;
    logic             w_grant_rd;
    logic             w_grant_wr;
    logic             w_cmd_fire;
    logic             w_last_beat;
    logic             w_tag_full;
    logic             w_tag_empty;
    logic [TAG_W-1:0] w_tag_dout;
    logic             w_resp_err;

    assign w_last_beat = (r_beat == r_hdr.len);
    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign dbg_state   = r_state;
    assign rinc_ar     = r_rinc_ar;
    assign rinc_aw     = r_rinc_aw;
    assign cmd_addr    = r_hdr.addr;
    assign cmd_wdata   = cmd_we ? rdata_w.data : '0;
    assign cmd_wstrb   = cmd_we ? rdata_w.strb : '0;

    // Next state, arbitration and per-state handshake outputs.
    always_comb begin
        w_next     = r_state;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        rinc_w     = 1'b0;
        winc_b     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the class not granted last wins.
                w_grant_rd = ~rempty_ar & (rempty_aw | ~r_last_rd);
                w_grant_wr = ~rempty_aw & (rempty_ar | r_last_rd);
                if (w_grant_rd)      w_next = ST_RD_BURST;
                else if (w_grant_wr) w_next = ST_WR_BURST;
            end
            ST_RD_BURST: begin
                cmd_valid = ~w_tag_full;
                if (cmd_valid && cmd_ready && w_last_beat) w_next = ST_IDLE;
            end
            ST_WR_BURST: begin
                cmd_valid = ~rempty_w;
                cmd_we    = 1'b1;
                rinc_w    = cmd_valid & cmd_ready;
                if (rinc_w && w_last_beat) w_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                winc_b = ~wfull_b;
                if (winc_b) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) r_state <= ST_IDLE;
        else             r_state <= w_next;
    end

    // Header capture on grant, address/beat stepping on each accepted command.
    // The header FIFO is popped in the cycle after the grant.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            r_hdr     <= '0;
            r_beat    <= '0;
            r_last_rd <= 1'b0;
            r_rinc_ar <= 1'b0;
            r_rinc_aw <= 1'b0;
        end else begin
            r_rinc_ar <= w_grant_rd;
            r_rinc_aw <= w_grant_wr;
            if (w_grant_rd) begin
                r_hdr     <= rdata_ar;
                r_beat    <= '0;
                r_last_rd <= 1'b1;
            end else if (w_grant_wr) begin
                r_hdr     <= rdata_aw;
                r_beat    <= '0;
                r_last_rd <= 1'b0;
            end else if (w_cmd_fire) begin
                r_hdr.addr <= next_addr(r_hdr.addr, r_hdr.size, r_hdr.burst, r_hdr.len);
                r_beat     <= r_beat + 8'd1;
            end
        end
    end

`ifdef NASTI_WLAST_CHECK_EN
    logic r_err;
    logic w_unused_wuser;
    assign w_unused_wuser = ^rdata_w.user;
    assign w_resp_err     = r_err;

    // Sticky per-burst flag for a W last bit that disagrees with the beat count.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn)                                     r_err <= 1'b0;
        else if (w_grant_wr)                                 r_err <= 1'b0;
        else if (rinc_w && (rdata_w.last != w_last_beat))    r_err <= 1'b1;
    end
`else
    logic w_unused_wlast;
    assign w_unused_wlast = ^{rdata_w.last, rdata_w.user};
    assign w_resp_err     = 1'b0;
`endif

    // Write response built from the captured AW header.
    always_comb begin
        wdata_b      = '0;
        wdata_b.id   = r_hdr.id;
        wdata_b.user = r_hdr.user;
        wdata_b.resp = w_resp_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Read return path, independent of the FSM.
    assign rd_ready = ~wfull_r;
    assign winc_r   = rd_valid & ~wfull_r;

    // R beat labelled with the oldest outstanding tag.
    always_comb begin
        wdata_r      = '0;
        wdata_r.id   = w_tag_dout[TAG_W-1 -: C_NASTI_ID_WIDTH];
        wdata_r.data = rd_data;
        wdata_r.last = w_tag_dout[0];
        wdata_r.resp = RESP_OKAY;
        wdata_r.user = w_tag_dout[1 +: C_NASTI_USER_WIDTH];
    end

    nasti_tag_fifo #(
        .DEPTH(C_RD_TAGS),
        .WIDTH(TAG_W)
    ) u_tags (
        .i_clk  (core_clk),
        .i_arstn(core_arstn),
        .i_push (w_cmd_fire & ~cmd_we),
        .i_din  ({r_hdr.id, r_hdr.user, w_last_beat}),
        .i_pop  (winc_r),
        .o_dout (w_tag_dout),
        .o_full (w_tag_full),
        .o_empty(w_tag_empty)
    );

    // Memory must never return data for a beat that was not issued.
    a_rd_has_tag: assert property (@(posedge core_clk) disable iff (!core_arstn)
        !(rd_valid && w_tag_empty));

endmodule

// File: tb/tb_nasti_burst_engine.sv
// Bench for nasti_burst_engine: behavioural FIFO/memory models, directed
// cases and a randomized mix checked against per-class expectation queues.
module tb_nasti_burst_engine;
    import nasti_trans_pkg::*;

    logic core_clk;
    logic core_arstn;
    ar_trans rdata_ar;
    logic rempty_ar, rinc_ar;
    aw_trans rdata_aw;
    logic rempty_aw, rinc_aw;
    w_trans rdata_w;
    logic rempty_w, rinc_w;
    r_trans wdata_r;
    logic wfull_r, winc_r;
    b_trans wdata_b;
    logic wfull_b, winc_b;
    logic cmd_valid, cmd_ready, cmd_we;
    logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr;
    logic [C_NASTI_DATA_WIDTH-1:0] cmd_wdata;
    logic [C_NASTI_STRB_WIDTH-1:0] cmd_wstrb;
    logic rd_valid, rd_ready;
    logic [C_NASTI_DATA_WIDTH-1:0] rd_data;
    logic [1:0] dbg_state;

    nasti_burst_engine #(.C_RD_TAGS(8)) dut (
        .core_clk(core_clk), .core_arstn(core_arstn),
        .rdata_ar(rdata_ar), .rempty_ar(rempty_ar), .rinc_ar(rinc_ar),
        .rdata_aw(rdata_aw), .rempty_aw(rempty_aw), .rinc_aw(rinc_aw),
        .rdata_w(rdata_w), .rempty_w(rempty_w), .rinc_w(rinc_w),
        .wdata_r(wdata_r), .wfull_r(wfull_r), .winc_r(winc_r),
        .wdata_b(wdata_b), .wfull_b(wfull_b), .winc_b(winc_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // ---------------- bench state ----------------
    int n_vec;
    int n_err;
    int p_ready, p_rvalid, p_wfull_r, p_wfull_b;
    int n_rd_acc;
    int n_b;
    logic [1:0] last_b_resp;
    bit prev_stall;
    logic [16:0] prev_cmd;

    ax_trans ar_fifo[$];
    ax_trans aw_fifo[$];
    w_trans  w_fifo[$];
    logic [15:0]  exp_raddr_q[$];
    logic [10:0]  exp_rmeta_q[$];
    logic [87:0]  exp_wcmd_q[$];
    logic [76:0]  exp_r_q[$];
    logic [11:0]  exp_b_q[$];
    logic [63:0]  mem_q[$];
    int           we_log[$];
    logic [15:0]  addr_log[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i of a burst, from the burst definition.
    function automatic logic [15:0] beat_addr(input logic [15:0] start, input int i,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input logic [7:0] len);
        int sz, wb, base, s;
        sz = 1 << size;
        s  = int'(start);
        if (burst == 2'b00) return start;
        if (burst == 2'b10) begin
            wb   = (int'(len) + 1) * sz;
            base = s - (s % wb);
            return 16'(base + ((s - base + i * sz) % wb));
        end
        if (i == 0) return start;
        return 16'((s - (s % sz)) + i * sz);
    endfunction

    task automatic push_ar(input logic [8:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic user);
        ax_trans t;
        t.id = id; t.addr = addr; t.len = len; t.size = size; t.burst = burst; t.user = user;
        ar_fifo.push_back(t);
        for (int i = 0; i <= int'(len); i++) begin
            exp_raddr_q.push_back(beat_addr(addr, i, size, burst, len));
            exp_rmeta_q.push_back({id, (i == int'(len)), user});
        end
    endtask

    task automatic push_aw(input logic [8:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic user,
                           input int bad_beat);
        ax_trans t;
        w_trans w;
        logic [1:0] resp;
        t.id = id; t.addr = addr; t.len = len; t.size = size; t.burst = burst; t.user = user;
        aw_fifo.push_back(t);
        for (int i = 0; i <= int'(len); i++) begin
            w.data = {$urandom, $urandom};
            w.strb = 8'($urandom);
            w.last = (i == int'(len)) ^ (i == bad_beat);
            w.user = 1'($urandom);
            w_fifo.push_back(w);
            exp_wcmd_q.push_back({beat_addr(addr, i, size, burst, len), w.data, w.strb});
        end
`ifdef NASTI_WLAST_CHECK_EN
        resp = (bad_beat >= 0) ? 2'b10 : 2'b00;
`else
        resp = 2'b00;
`endif
        exp_b_q.push_back({id, resp, user});
    endtask

    // Observe one cycle's outputs (settled, before the active edge) and
    // update the FIFO/memory models and scoreboards.
    task automatic observe();
        logic [10:0] meta;
        logic [63:0] d;
        if (prev_stall) begin
            check("cmd_hold_valid", cmd_valid, 1);
            check("cmd_hold_payload", {cmd_we, cmd_addr}, prev_cmd);
        end
        prev_stall = cmd_valid && !cmd_ready;
        prev_cmd   = {cmd_we, cmd_addr};
        check("rd_ready", rd_ready, !wfull_r);
        check("winc_r", winc_r, rd_valid && !wfull_r);
        if (rinc_ar) begin
            check("rinc_ar_on_empty", ar_fifo.size() == 0, 0);
            if (ar_fifo.size() > 0) void'(ar_fifo.pop_front());
        end
        if (rinc_aw) begin
            check("rinc_aw_on_empty", aw_fifo.size() == 0, 0);
            if (aw_fifo.size() > 0) void'(aw_fifo.pop_front());
        end
        check("rinc_w", rinc_w, cmd_valid && cmd_ready && cmd_we);
        if (cmd_valid && cmd_ready) begin
            we_log.push_back(int'(cmd_we));
            addr_log.push_back(cmd_addr);
            if (cmd_we) begin
                if (exp_wcmd_q.size() == 0) check("wcmd_unexpected", 1, 0);
                else check("wcmd", {cmd_addr, cmd_wdata, cmd_wstrb}, exp_wcmd_q.pop_front());
            end else begin
                n_rd_acc++;
                if (exp_raddr_q.size() == 0) check("rcmd_unexpected", 1, 0);
                else begin
                    check("rcmd_addr", cmd_addr, exp_raddr_q.pop_front());
                    meta = exp_rmeta_q.pop_front();
                    d = {$urandom, $urandom};
                    mem_q.push_back(d);
                    exp_r_q.push_back({meta[10:2], d, meta[1], 2'b00, meta[0]});
                end
            end
        end
        if (rinc_w && w_fifo.size() > 0) void'(w_fifo.pop_front());
        if (rd_valid && rd_ready && mem_q.size() > 0) void'(mem_q.pop_front());
        if (winc_r) begin
            if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
            else check("r_beat", wdata_r, exp_r_q.pop_front());
        end
        if (winc_b) begin
            n_b++;
            last_b_resp = wdata_b.resp;
            check("winc_b_while_full", wfull_b, 0);
            if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
            else check("b_resp", wdata_b, exp_b_q.pop_front());
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then observe.
    task automatic tick();
        @(negedge core_clk);
        rempty_ar = (ar_fifo.size() == 0);
        rdata_ar  = rempty_ar ? '0 : ar_fifo[0];
        rempty_aw = (aw_fifo.size() == 0);
        rdata_aw  = rempty_aw ? '0 : aw_fifo[0];
        rempty_w  = (w_fifo.size() == 0);
        rdata_w   = rempty_w ? '0 : w_fifo[0];
        cmd_ready = ($urandom_range(99) < p_ready);
        wfull_r   = ($urandom_range(99) < p_wfull_r);
        wfull_b   = ($urandom_range(99) < p_wfull_b);
        rd_valid  = (mem_q.size() > 0) && ($urandom_range(99) < p_rvalid);
        rd_data   = (mem_q.size() > 0) ? mem_q[0] : '0;
        #1;
        observe();
    endtask

    function automatic bit all_idle();
        return ar_fifo.size() == 0 && aw_fifo.size() == 0 && w_fifo.size() == 0 &&
               exp_raddr_q.size() == 0 && exp_wcmd_q.size() == 0 && exp_r_q.size() == 0 &&
               exp_b_q.size() == 0 && mem_q.size() == 0 && dbg_state == 2'd0;
    endfunction

    task automatic clear_models();
        ar_fifo.delete(); aw_fifo.delete(); w_fifo.delete();
        exp_raddr_q.delete(); exp_rmeta_q.delete(); exp_wcmd_q.delete();
        exp_r_q.delete(); exp_b_q.delete(); mem_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic idle_inputs();
        rdata_ar = '0; rempty_ar = 1; rdata_aw = '0; rempty_aw = 1;
        rdata_w = '0; rempty_w = 1; cmd_ready = 0; wfull_r = 0; wfull_b = 0;
        rd_valid = 0; rd_data = '0;
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        core_arstn = 0;
        idle_inputs();
        clear_models();
        repeat (2) @(negedge core_clk);
        core_arstn = 1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            tick();
            n++;
        end
        check(tag, n < budget, 1);
        if (n >= budget) do_reset();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int exp_we[6];
        logic [15:0] exp_a[4];
        n_vec = 0; n_err = 0; n_rd_acc = 0; n_b = 0; last_b_resp = 2'b11;
        prev_stall = 0; prev_cmd = '0;
        p_ready = 100; p_rvalid = 100; p_wfull_r = 0; p_wfull_b = 0;
        idle_inputs();

        // Reset state, with headers presented so pops would be visible.
        core_arstn = 0;
        rempty_ar = 0; rempty_aw = 0;
        repeat (3) @(negedge core_clk);
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_rinc_ar", rinc_ar, 0);
        check("rst_rinc_aw", rinc_aw, 0);
        check("rst_rinc_w", rinc_w, 0);
        check("rst_winc_r", winc_r, 0);
        check("rst_winc_b", winc_b, 0);
        check("rst_state", dbg_state, 0);
        idle_inputs();
        @(negedge core_clk);
        core_arstn = 1;

        // INCR read burst, plus grant-to-command latency.
        addr_log.delete();
        push_ar(9'd5, 16'h0100, 8'd3, 3'd3, BURST_INCR, 1'b0);
        tick();
        check("lat_grant_cycle", cmd_valid, 0);
        tick();
        check("lat_first_cmd", cmd_valid, 1);
        drain("incr_read_done", 200);
        exp_a = '{16'h0100, 16'h0108, 16'h0110, 16'h0118};
        check("incr_beats", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) check("incr_addr", addr_log[i], exp_a[i]);

        // WRAP write burst.
        addr_log.delete();
        n_b = 0;
        push_aw(9'd7, 16'h0038, 8'd3, 3'd3, BURST_WRAP, 1'b1, -1);
        drain("wrap_write_done", 200);
        exp_a = '{16'h0038, 16'h0020, 16'h0028, 16'h0030};
        check("wrap_beats", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) check("wrap_addr", addr_log[i], exp_a[i]);
        check("wrap_b_count", n_b, 1);
        check("wrap_b_resp", last_b_resp, 2'b00);

        // Read/write alternation on ties, starting from reset.
        do_reset();
        we_log.delete();
        push_ar(9'd1, 16'h0000, 8'd1, 3'd2, BURST_INCR, 1'b0);
        push_aw(9'd2, 16'h0040, 8'd1, 3'd2, BURST_INCR, 1'b1, -1);
        push_ar(9'd3, 16'h0080, 8'd0, 3'd2, BURST_INCR, 1'b0);
        push_aw(9'd4, 16'h00C0, 8'd0, 3'd2, BURST_INCR, 1'b0, -1);
        drain("arb_done", 300);
        exp_we = '{0, 0, 1, 1, 0, 1};
        check("arb_beats", we_log.size(), 6);
        for (int i = 0; i < 6 && i < we_log.size(); i++) check("arb_order", we_log[i], exp_we[i]);

        // Tag FIFO back-pressure: R FIFO full, ten single-beat reads.
        p_wfull_r = 100;
        base = n_rd_acc;
        for (int i = 0; i < 10; i++) push_ar(9'(16 + i), 16'(i * 8), 8'd0, 3'd3, BURST_INCR, 1'(i));
        repeat (40) tick();
        check("tags_outstanding", n_rd_acc - base, 8);
        check("tagfull_cmd_valid", cmd_valid, 0);
        check("tagfull_rd_ready", rd_ready, 0);
        p_wfull_r = 0;
        drain("tagfull_drain", 400);
        check("tagfull_total", n_rd_acc - base, 10);

        // W last flag disagreeing with the beat count.
        push_aw(9'd9, 16'h0200, 8'd1, 3'd3, BURST_INCR, 1'b0, 0);
        drain("wlast_done", 200);
`ifdef NASTI_WLAST_CHECK_EN
        check("wlast_resp", last_b_resp, 2'b10);
`else
        check("wlast_resp", last_b_resp, 2'b00);
`endif

        // Asynchronous reset in the middle of a write burst.
        push_aw(9'd4, 16'h0300, 8'd7, 3'd3, BURST_INCR, 1'b0, -1);
        repeat (4) tick();
        check("midburst_active", dbg_state, 2);
        @(negedge core_clk);
        #2;
        core_arstn = 0;
        rd_valid = 0;
        #1;
        check("arst_cmd_valid", cmd_valid, 0);
        check("arst_rinc_w", rinc_w, 0);
        check("arst_rinc_ar", rinc_ar, 0);
        check("arst_rinc_aw", rinc_aw, 0);
        check("arst_winc_b", winc_b, 0);
        check("arst_winc_r", winc_r, 0);
        check("arst_state", dbg_state, 0);
        clear_models();
        idle_inputs();
        repeat (2) @(negedge core_clk);
        core_arstn = 1;
        push_ar(9'd11, 16'h0010, 8'd0, 3'd0, BURST_FIXED, 1'b1);
        drain("post_reset_read", 100);

        // Randomized mix with random back-pressure on every interface.
        p_ready = 70; p_rvalid = 60; p_wfull_r = 20; p_wfull_b = 30;
        for (int t = 0; t < 60; t++) begin
            logic [2:0]  sz;
            logic [1:0]  bt;
            logic [7:0]  ln;
            logic [15:0] a;
            sz = 3'($urandom_range(3));
            bt = 2'($urandom_range(3));
            a  = 16'($urandom);
            if (bt == 2'b10) begin
                ln = 8'((1 << $urandom_range(1, 3)) - 1);
                a  = {a[15:3], 3'b000};
            end else begin
                ln = 8'($urandom_range(7));
            end
            if ($urandom_range(1) == 1)
                push_ar(9'($urandom), a, ln, sz, bt, 1'($urandom));
            else
                push_aw(9'($urandom), a, ln, sz, bt, 1'($urandom),
                        ($urandom_range(9) == 0) ? int'($urandom_range(int'(ln))) : -1);
            if ($urandom_range(3) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        drain("random_done", 20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nasti_burst_engine.md
# nasti_burst_engine

Core-clock back end for the NASTI slave port. Consumes the AR, AW and W transaction FIFOs that the frontend fills, and expands each NASTI burst into per-beat memory commands with FIXED/INCR/WRAP address generation. Returns read data into the frontend's R FIFO and write responses into its B FIFO. Sits between the frontend FIFOs and the DDRx command scheduler, entirely in the core_clk domain.

## Interface
- C_NASTI_ID_WIDTH, 9, transaction id width
- C_NASTI_ADDR_WIDTH, 16, byte address width
- C_NASTI_DATA_WIDTH, 64, beat data width
- C_NASTI_USER_WIDTH, 1, user field width
- C_RD_TAGS, 8, read tag FIFO depth (power of 2, ≥2)
- core_clk  in  1  single clock
- core_arstn  in  1  reset, asynchronous, active-low
- rdata_ar / rempty_ar / rinc_ar  in/in/out  ar_trans/1/1  AR FIFO head, empty, pop
- rdata_aw / rempty_aw / rinc_aw  in/in/out  aw_trans/1/1  AW FIFO head, empty, pop
- rdata_w / rempty_w / rinc_w  in/in/out  w_trans/1/1  W FIFO head, empty, pop
- wdata_r / wfull_r / winc_r  out/in/out  r_trans/1/1  R FIFO data, full, push
- wdata_b / wfull_b / winc_b  out/in/out  b_trans/1/1  B FIFO data, full, push
- cmd_valid / cmd_ready  out/in  1/1  memory command handshake
- cmd_we  out  1  1 = write beat
- cmd_addr  out  C_NASTI_ADDR_WIDTH  beat byte address
- cmd_wdata / cmd_wstrb  out  DATA / DATA/8  write beat payload
- rd_valid / rd_ready  in/out  1/1  in-order read data return handshake
- rd_data  in  C_NASTI_DATA_WIDTH  read beat data

## Operation
- FIFO heads are show-ahead: rdata_* is valid while rempty_* is low; rinc_* pops at the clock edge.
- FSM states: IDLE, RD_BURST, WR_BURST, WR_RESP.
- IDLE: a read is pending when ~rempty_ar, a write when ~rempty_aw. If both are pending, grant the class not granted last (last_rd flag, resets to 0, so reads win first). On grant: capture the header (id, addr, len, size, burst, user), zero beat counter, pulse rinc_* for one cycle, go to RD_BURST/WR_BURST.
- RD_BURST: cmd_valid=~tag_full, cmd_we=0. On cmd_valid&cmd_ready: push tag {id, user, last=(beat==len)}, advance address, beat++. Accepting beat len returns the FSM to IDLE.
- WR_BURST: cmd_valid=~rempty_w, cmd_we=1, wdata/wstrb come from the W head. On accept: rinc_w=1 in the same cycle, advance address, beat++. Accepting beat len moves the FSM to WR_RESP.
- WR_RESP: winc_b=~wfull_b, b_id/b_user come from the captured header, b_resp=OKAY (2'b00) unless set by the check feature. On push: return to IDLE.
- Read return path runs independently of the FSM:
  - rd_ready=~wfull_r; winc_r=rd_valid&~wfull_r; tag popped on the same edge.
  - wdata_r = {tag.id, rd_data, tag.last, 2'b00, tag.user}.
  - rd_valid with the tag FIFO empty is a memory protocol violation (assertion).
- Address arithmetic, with sz=1<<size:
  - FIXED (00): address held for all beats.
  - INCR (01), and reserved 11 treated as INCR: next = (addr & ~(sz-1)) + sz, modulo 2^ADDR_WIDTH.
  - WRAP (10): wb=(len+1)*sz; next = (addr & ~(wb-1)) | ((addr+sz) & (wb-1)).
- Beat counter is 8 bits; len=0 means a single beat.

## Timing
- Reset values: FSM=IDLE, all rinc_*/winc_*=0, cmd_valid=0, last_rd=0, tag FIFO empty. Reset clears every register asynchronously; in-flight bursts and tags are discarded.
- Grant-to-first-command latency: one cycle (grant in IDLE, cmd_valid in the next cycle).
- Back-to-back commands are issued every cycle while cmd_ready is high, the W head is non-empty and tag FIFO space exists.
- cmd_valid once high holds cmd_addr/cmd_we/cmd_wdata stable until accepted. Exception: in WR_BURST it drops only if W becomes empty, which it cannot do while the W head is unpopped.
- After the last beat, one IDLE cycle separates consecutive bursts.
- A simultaneous tag push and pop leaves the tag count unchanged.

## Configuration
- NASTI_WLAST_CHECK_EN defined:
  - During WR_BURST, w_last must equal (beat==len).
  - Any mismatch sets a sticky error flag for that burst, and b_resp becomes SLVERR (2'b10).
  - Beat count is still governed by aw_len.
- NASTI_WLAST_CHECK_EN undefined: w_last is ignored and b_resp is always OKAY.

## Structure
- Shared package nasti_trans_pkg holds ar_trans/aw_trans/w_trans/r_trans/b_trans and the burst/resp encodings (BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR).
- Sub-module nasti_tag_fifo: synchronous FIFO (C_RD_TAGS deep, width ID+USER+1) with full/empty flags, reset async active-low.

## Test plan
- AR {id=5, addr=0x100, len=3, size=3, INCR}, cmd_ready=1 → cmd_addr 0x100, 0x108, 0x110, 0x118. R beats carry id=5, and last=1 only on beat 3.
- AW {addr=0x38, len=3, size=3, WRAP} → cmd_addr 0x38, 0x20, 0x28, 0x30; one B with the AW id, resp=OKAY.
- AR and AW pending simultaneously from reset → read burst first, then write, then read again on the next tie.
- wfull_r held high with 8 reads issued → cmd_valid drops once 8 tags are outstanding; rd_ready=0. Releasing wfull_r drains all beats in order.
- With NASTI_WLAST_CHECK_EN, AW len=1 and w_last=1 on beat 0 → b_resp=2'b10. Without the macro → 2'b00.
- core_arstn asserted mid-write-burst → all outputs return to reset values immediately. A subsequent AR len=0 completes normally.
